// File: rtl/rv_pkg.sv
// Shared RV32 definitions: M-extension funct3 codes, muldiv FSM
// state encoding, default XLEN and operand signedness helpers.
package rv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] MULDIV_MUL    = 3'd0;
   localparam logic [2:0] MULDIV_MULH   = 3'd1;
   localparam logic [2:0] MULDIV_MULHSU = 3'd2;
   localparam logic [2:0] MULDIV_MULHU  = 3'd3;
   localparam logic [2:0] MULDIV_DIV    = 3'd4;
   localparam logic [2:0] MULDIV_DIVU   = 3'd5;
   localparam logic [2:0] MULDIV_REM    = 3'd6;
   localparam logic [2:0] MULDIV_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

   function automatic logic a_signed(input logic [2:0] f);
      return f inside {MULDIV_MUL, MULDIV_MULH, MULDIV_MULHSU,
                       MULDIV_DIV, MULDIV_REM};
   endfunction

   function automatic logic b_signed(input logic [2:0] f);
      return f inside {MULDIV_MUL, MULDIV_MULH,
                       MULDIV_DIV, MULDIV_REM};
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude/sign prep, shared shift-add / restoring-divide register, sign fix.
// Ports: clk, reset(async low), load, step, op, a, b -> fin (value after step).
module muldiv_datapath
   import rv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] fin
);

   // acc: {product hi, multiplier} for MUL*, {remainder, dividend/quotient} for DIV*
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_nxt;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   m;
   logic [2:0]        op_q;
   logic              neg_q;
   logic              neg_r;

   logic            sa, sb, bz;
   logic [XLEN-1:0] ma, mb;
   logic [XLEN-1:0] hi, lo, dif, q, r;
   logic [XLEN:0]   sum, rs;
   logic            ge;

   always_comb begin
      sa = a_signed(op) & a[XLEN-1];
      sb = b_signed(op) & b[XLEN-1];
      ma = sa ? -a : a;
      mb = sb ? -b : b;
      bz = (b == '0);
   end

   always_comb begin
      hi  = acc[2*XLEN-1:XLEN];
      lo  = acc[XLEN-1:0];
      sum = {1'b0, hi} + {1'b0, m};
      rs  = {hi, lo[XLEN-1]};
      ge  = (rs >= {1'b0, m});
      dif = rs[XLEN-1:0] - m;
      acc_nxt = acc;
      if (op_q[2])
         acc_nxt = {ge ? dif : rs[XLEN-1:0], lo[XLEN-2:0], ge};
      else if (lo[0])
         acc_nxt = {sum, lo[XLEN-1:1]};
      else
         acc_nxt = {1'b0, hi, lo[XLEN-1:1]};
   end

   always_comb begin
      prod = neg_q ? -acc_nxt : acc_nxt;
      q    = acc_nxt[XLEN-1:0];
      r    = acc_nxt[2*XLEN-1:XLEN];
      fin  = '0;
      unique case (op_q)
         MULDIV_MUL:  fin = prod[XLEN-1:0];
         MULDIV_MULH,
         MULDIV_MULHSU,
         MULDIV_MULHU: fin = prod[2*XLEN-1:XLEN];
         MULDIV_DIV,
         MULDIV_DIVU: fin = neg_q ? -q : q;
         default:     fin = neg_r ? -r : r;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc   <= '0;
         m     <= '0;
         op_q  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (load) begin
         op_q  <= op;
         neg_r <= sa;
         if (op[2]) begin
            // a zero divisor keeps an all-ones quotient unsigned
            neg_q <= (sa ^ sb) & ~bz;
            acc   <= {{XLEN{1'b0}}, ma};
            m     <= mb;
         end else begin
            neg_q <= sa ^ sb;
            acc   <= {{XLEN{1'b0}}, mb};
            m     <= ma;
         end
      end else if (step) begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, counter, tag, special cases.
// Ports: clk, reset, start, kill, op, a, b, rd_in -> busy, done, result, rd_out.
module ex_muldiv_unit
   import rv_pkg::*;
#(
   parameter int XLEN         = XLEN_DEF,
   parameter int FAST_SPECIAL = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam int CW = $clog2(XLEN);

   md_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            accept, stepping, last;
   logic            bz, ovf, special;
   logic [XLEN-1:0] spec_val;
   logic [XLEN-1:0] fin;

   always_comb begin
      accept   = (state_q == ST_IDLE) & start & ~kill;
      stepping = (state_q == ST_CALC) & ~kill;
      last     = (cnt_q == CW'(XLEN - 1));
      bz       = (b == '0);
      ovf      = op[2] & ~op[0]
               & (a == {1'b1, {(XLEN-1){1'b0}}})
               & (b == '1);
      special  = (FAST_SPECIAL != 0) & op[2] & (bz | ovf);
      spec_val = '0;
      unique case (1'b1)
         bz:      spec_val = op[1] ? a : '1;
         default: spec_val = op[1] ? '0 : a;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
         ST_CALC: begin
            if (kill)      state_d = ST_IDLE;
            else if (last) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // busy is gated by reset so an asserted start cannot stall during reset
   assign busy = reset & (accept | (state_q == ST_CALC));
   assign done = (state_q == ST_DONE) & ~kill;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         result  <= '0;
         rd_out  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rd_out <= rd_in;
            cnt_q  <= '0;
            if (special) result <= spec_val;
         end
         if (stepping) begin
            cnt_q <= cnt_q + CW'(1);
            if (last) result <= fin;
         end
      end
   end

   muldiv_datapath #(
      .XLEN(XLEN)
   ) u_dp (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .step  (stepping),
      .op    (op),
      .a     (a),
      .b     (b),
      .fin   (fin)
   );

endmodule
